// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: 32-iteration multiply/divide sequencer for the EX stage.
// Accepts MULT/MULTU/DIV/DIVU, stalls the pipeline while iterating and
// writes the architectural HI/LO pair when the operation completes.
module ex_muldiv_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] srcLeft,
   input  logic [31:0] srcRight,
   input  logic        flush,
   output logic        stallReq,
   output logic        resultValid,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   // Operation context captured at issue
   logic        is_div;
   logic        neg_quot;      // product / quotient must be negated
   logic        neg_rem;       // remainder takes the dividend's sign
   logic [31:0] mag_a;         // multiplicand, or dividend shifted out MSB-first
   logic [31:0] mag_b;         // multiplier shifted out LSB-first, or divisor
   logic [63:0] acc;           // MUL: {product_hi, product_lo}; DIV: {rem, quot}
   logic [4:0]  cnt;

   // Issue-time decode
   logic        op_div;
   logic        op_signed;
   logic        left_neg;
   logic        right_neg;
   logic        issue;
   logic        div_zero;

   // One iteration of the active loop
   logic [32:0] mul_sum;
   logic [32:0] div_rem;
   logic [32:0] div_diff;
   logic        div_ge;
   logic [63:0] acc_step;
   logic [63:0] fixed;

   // Absolute value for signed operands; unsigned operands pass through
   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   // Sign fix-up of the raw magnitude result, returned as {hi, lo}
   function automatic logic [63:0] sign_fix(input logic [63:0] raw, input logic div,
                                            input logic nq, input logic nr);
      logic [31:0] r_hi;
      logic [31:0] r_lo;
      if (!div) begin
         return nq ? (~raw + 64'd1) : raw;
      end
      r_hi = nr ? (~raw[63:32] + 32'd1) : raw[63:32];
      r_lo = nq ? (~raw[31:0] + 32'd1) : raw[31:0];
      return {r_hi, r_lo};
   endfunction

   // Decode the incoming request and decide whether it is accepted
   always_comb begin
      op_div    = op[1];
      op_signed = ~op[0];
      left_neg  = op_signed & srcLeft[31];
      right_neg = op_signed & srcRight[31];
      issue     = (state == IDLE) & start & ~flush;
      div_zero  = op_div & (srcRight == 32'd0);
      stallReq  = issue | (state == RUN);
   end

   // Single iteration: shift-add for multiply, restoring step for divide
   always_comb begin
      mul_sum  = {1'b0, acc[63:32]} + {1'b0, (mag_b[0] ? mag_a : 32'd0)};
      div_rem  = {acc[63:32], mag_a[31]};
      div_ge   = (div_rem >= {1'b0, mag_b});
      div_diff = div_rem - {1'b0, mag_b};
      if (is_div) begin
         acc_step = {(div_ge ? div_diff[31:0] : div_rem[31:0]), acc[30:0], div_ge};
      end else begin
         acc_step = {mul_sum, acc[31:1]};
      end
      fixed = sign_fix(acc_step, is_div, neg_quot, neg_rem);
   end

   // Next-state logic; flush overrides everything
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (issue) state_next = div_zero ? DONE : RUN;
         RUN:  if (cnt == 5'd31) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Operand capture, iteration registers and HI/LO write-back
   always_ff @(posedge clk) begin
      if (rst) begin
         is_div      <= 1'b0;
         neg_quot    <= 1'b0;
         neg_rem     <= 1'b0;
         mag_a       <= 32'd0;
         mag_b       <= 32'd0;
         acc         <= 64'd0;
         cnt         <= 5'd0;
         hi          <= 32'd0;
         lo          <= 32'd0;
         resultValid <= 1'b0;
      end else begin
         resultValid <= 1'b0;
         if (issue) begin
            is_div   <= op_div;
            neg_quot <= left_neg ^ right_neg;
            neg_rem  <= left_neg;
            mag_a    <= magnitude(srcLeft, left_neg);
            mag_b    <= magnitude(srcRight, right_neg);
            acc      <= 64'd0;
            cnt      <= 5'd0;
            if (div_zero) begin
               // Divide by zero leaves the raw dividend in HI, all-ones in LO
               hi          <= srcLeft;
               lo          <= 32'hFFFF_FFFF;
               resultValid <= 1'b1;
            end
         end else if (state == RUN && !flush) begin
            acc <= acc_step;
            cnt <= cnt + 5'd1;
            if (is_div) mag_a <= {mag_a[30:0], 1'b0};
            else        mag_b <= {1'b0, mag_b[31:1]};
            if (cnt == 5'd31) begin
               hi          <= fixed[63:32];
               lo          <= fixed[31:0];
               resultValid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: expected HI/LO pairs are queued at
// issue and compared when resultValid pulses.
module tb_ex_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] srcLeft;
   logic [31:0] srcRight;
   logic        flush;
   logic        stallReq;
   logic        resultValid;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] last_exp = 64'd0;

   ex_muldiv_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .srcLeft(srcLeft), .srcRight(srcRight), .flush(flush),
      .stallReq(stallReq), .resultValid(resultValid), .hi(hi), .lo(lo)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference model: native 64-bit arithmetic, result as {hi, lo}
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      p  = 64'd0;
      case (o)
         2'b00: begin q = sa * sb; p = q; end
         2'b01: p = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
         end
         default: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      if (resultValid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_valid", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.tag, {hi, lo}, e.val);
         end
      end
   end

   task automatic drive_issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              input string tag, input bit push);
      @(negedge clk);
      op = o; srcLeft = a; srcRight = b; start = 1'b1;
      if (push) begin
         sb_q.push_back('{tag, model(o, a, b)});
         last_exp = model(o, a, b);
      end
      #1;
      chk({tag, "_issue_stall"}, {63'd0, stallReq}, 64'd1);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int lat, stalls, exp_lat;
      exp_lat = (o[1] && b == 32'd0) ? 1 : 33;
      drive_issue(o, a, b, tag, 1'b1);
      lat = 0;
      stalls = 1;
      while (1) begin
         @(negedge clk);
         lat++;
         if (resultValid) break;
         if (stallReq) stalls++;
         if (lat >= 60) begin
            chk({tag, "_timeout"}, 64'd1, 64'd0);
            break;
         end
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_stalls"}, 64'(stalls), 64'(exp_lat));
      @(negedge clk);
      chk({tag, "_pulse_end"}, {63'd0, resultValid}, 64'd0);
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (resultValid) seen++;
      end
      chk(tag, 64'(seen), 64'd0);
   endtask

   // Bound on total run time
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Stimulus
   initial begin
      int first, second, cyc;
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; srcLeft = 32'd0; srcRight = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_hilo", {hi, lo}, 64'd0);
      chk("reset_valid", {63'd0, resultValid}, 64'd0);
      chk("reset_stall", {63'd0, stallReq}, 64'd0);

      // Directed cases
      run_op(2'b01, 32'd7, 32'd6, "multu_7x6");
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      run_op(2'b00, -32'sd3, 32'd5, "mult_m3x5");
      run_op(2'b10, -32'sd7, 32'd2, "div_m7d2");
      run_op(2'b11, 32'd100, 32'd2, "divu_100d2");
      run_op(2'b11, 32'd100, 32'd0, "divu_by0");
      run_op(2'b10, -32'sd5, 32'd0, "div_by0");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin");

      // Random cases across all four ops
      for (int i = 0; i < 12; i++) begin
         run_op(2'(i % 4), $urandom, $urandom, $sformatf("rand%0d", i));
      end

      // Flush at the tenth RUN cycle
      drive_issue(2'b00, 32'd9, -32'sd2, "flushed", 1'b0);
      repeat (10) @(negedge clk);
      chk("flush_pre_stall", {63'd0, stallReq}, 64'd1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_stall", {63'd0, stallReq}, 64'd0);
      chk("flush_valid", {63'd0, resultValid}, 64'd0);
      chk("flush_hilo_hold", {hi, lo}, last_exp);
      expect_quiet("flush_no_result", 40);
      chk("flush_hilo_after", {hi, lo}, last_exp);

      // Flush wins over start in the same cycle
      @(negedge clk);
      op = 2'b01; srcLeft = 32'd3; srcRight = 32'd3; start = 1'b1; flush = 1'b1;
      #1 chk("flush_start_stall", {63'd0, stallReq}, 64'd0);
      @(posedge clk);
      #1 begin start = 1'b0; flush = 1'b0; end
      @(negedge clk);
      chk("flush_start_idle", {63'd0, stallReq}, 64'd0);
      expect_quiet("flush_start_no_result", 40);

      // Reset in the middle of RUN
      drive_issue(2'b01, 32'd5, 32'd5, "reset_mid", 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      chk("rst_mid_valid", {63'd0, resultValid}, 64'd0);
      chk("rst_mid_stall", {63'd0, stallReq}, 64'd0);
      expect_quiet("rst_mid_no_result", 40);
      run_op(2'b00, -32'sd4, -32'sd6, "after_rst");

      // start held high across DONE: one op per issue, re-issue in first IDLE cycle
      @(negedge clk);
      op = 2'b01; srcLeft = 32'd3; srcRight = 32'd4; start = 1'b1;
      sb_q.push_back('{"held_1", model(2'b01, 32'd3, 32'd4)});
      sb_q.push_back('{"held_2", model(2'b01, 32'd3, 32'd4)});
      first = -1; second = -1; cyc = 0;
      while (cyc < 100 && second < 0) begin
         @(negedge clk);
         cyc++;
         if (resultValid) begin
            if (first < 0) begin
               first = cyc;
               chk("held_done_stall", {63'd0, stallReq}, 64'd0);
               @(negedge clk);
               cyc++;
               chk("held_reissue_stall", {63'd0, stallReq}, 64'd1);
               @(posedge clk);
               #1 start = 1'b0;
            end else begin
               second = cyc;
            end
         end
      end
      start = 1'b0;
      chk("held_first_lat", 64'(first), 64'd33);
      chk("held_second_lat", 64'(second), 64'd67);
      expect_quiet("held_no_third", 40);

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Multi-cycle multiply/divide sequencer for the EX stage of the toy MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX decode, runs a 32-iteration shift-add or restoring-divide loop, and raises a stall request to the pipeline controller while busy. On completion it updates the architectural HI/LO registers. Single-cycle logic and arithmetic ops never enter this block.

## Interface
- No parameters; data width fixed at 32 (`WORD_BUS`).
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  issue request from EX; only sampled in IDLE
- op  in  2  2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
- srcLeft  in  32  multiplicand / dividend (rs)
- srcRight  in  32  multiplier / divisor (rt)
- flush  in  1  pipeline flush (exception/branch squash); aborts operation
- stallReq  out  1  combinational; holds the pipeline while the operation is in flight
- resultValid  out  1  registered; one-cycle pulse when HI/LO were just written
- hi  out  32  HI register (MULT: product[63:32]; DIV: remainder)
- lo  out  32  LO register (MULT: product[31:0]; DIV: quotient)

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, flush=0:
  - Latch op, sign flags and the magnitudes of the operands. Signed ops take the absolute value; unsigned ops pass operands through.
  - Clear the 64-bit accumulator and the 5-bit counter.
  - Go to RUN, except DIV/DIVU with srcRight==0, which goes straight to DONE.
- RUN: one iteration per cycle; counter increments; after the iteration with counter==31, go to DONE.
  - Multiply: shift-add, LSB-first over the multiplier.
  - Divide: restoring, one quotient bit per cycle, MSB-first.
- DONE: always returns to IDLE on the next edge.
  - On entry to DONE, apply sign fix-up and write hi/lo.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if signs differ; remainder takes the sign of the dividend.
  - resultValid=1 for exactly the DONE cycle.
- Divide by zero: hi=srcLeft (unmodified), lo=32'hFFFFFFFF, for both DIV and DIVU.
- Signed overflow case, DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0. This falls out of 33-bit magnitude handling with no special case.
- start while in RUN/DONE is ignored. The pipeline is stalled then, so the same instruction must not re-issue.
- flush in any state: next state IDLE, hi/lo not written, resultValid stays 0. A flush takes priority over start in the same cycle.
- hi/lo hold their value in every other cycle.

## Timing
- stallReq = (state==IDLE & start & ~flush) | (state==RUN). It is low in DONE so the instruction retires that cycle.
- Accepted at edge E0:
  - RUN is occupied from E0 to E32.
  - DONE lasts from E32 to E33, with resultValid high; hi/lo are valid from E32.
  - IDLE is re-entered at E33.
  - Total latency is 33 cycles from issue to resultValid.
  - stallReq is high for the 33 cycles from the issue cycle through the last RUN cycle.
- Divide by zero: DONE lasts from E0 to E1, resultValid is high in that cycle, and stallReq is high only in the issue cycle.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE, i.e. from E33 on.
- Reset values: state IDLE, hi=0, lo=0, resultValid=0, counter=0, accumulator=0. stallReq=0 unless start is asserted. A reset mid-operation discards the operation.

## Test plan
- MULTU 7 x 6 at E0: stallReq high for 33 cycles, resultValid in the cycle after E32, hi=0, lo=42.
- MULTU 32'hFFFFFFFF x 32'hFFFFFFFF: hi=32'hFFFFFFFE, lo=32'h00000001.
- MULT -3 x 5: hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
- DIV -7 / 2: lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- DIVU 100 / 2: lo=50, hi=0.
- DIVU 100 / 0: resultValid one cycle after issue, hi=100, lo=32'hFFFFFFFF.
- DIV 32'h80000000 / -1: lo=32'h80000000, hi=0.
- MULT in flight, flush asserted at RUN cycle 10: IDLE next cycle, stallReq low, no resultValid, hi/lo keep their prior values.
- rst asserted mid-RUN: all outputs zero next cycle; a following start runs normally.
- start held high across DONE: exactly one operation per issue; the second is accepted in the first IDLE cycle.
